// File: rtl/filter_rule_commit_ctrl.sv
// filter_rule_commit_ctrl: shadow/active rule set controller for the
// two-rule RX filter. Software fills shadow words, then requests a commit;
// the shadow set is copied to the active rule outputs only at an AXIS
// packet boundary seen on the ingress tap, or aborted after a timeout.
//
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   wr_en/wr_addr/wr_data  shadow register write port
//   commit_req             single-cycle commit request
//   mon_tvalid/tready/tlast ingress AXIS handshake tap
//   busy, pause_req        commit pending (WAIT_BOUNDARY)
//   commit_done/err        one-cycle result pulses
//   wr_err                 one-cycle pulse: write dropped while busy
//   rule{0,1}_*            active rule outputs (registered)
//   commit_count/timeout_count  statistics, built only when the
//                          FILTER_COMMIT_STATS_EN macro is defined
module filter_rule_commit_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             commit_req,
    input  logic             mon_tvalid,
    input  logic             mon_tready,
    input  logic             mon_tlast,
    output logic             busy,
    output logic             commit_done,
    output logic             commit_err,
    output logic             wr_err,
    output logic             pause_req,
    output logic [31:0]      rule0_ipv4_addr,
    output logic [127:0]     rule0_ipv6_addr,
    output logic [31:0]      rule0_port,
    output logic [31:0]      rule1_ipv4_addr,
    output logic [127:0]     rule1_ipv6_addr,
    output logic [31:0]      rule1_port,
    output logic [CNT_W-1:0] commit_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_wr_err;
    logic          r_in_pkt;
    logic [TW-1:0] r_tmo;
    logic [31:0]   r_sh  [12];
    logic [31:0]   r_act [12];

    logic          w_beat;
    logic          w_bound;
    logic          w_slot;
    logic [3:0]    w_idx;
    logic          w_wr_ok;
    logic          w_do_commit;
    logic          w_do_abort;

    assign w_beat  = mon_tvalid & mon_tready;
    // Safe to swap rules: line idle between packets, or the last beat
    // of the current packet is being accepted this cycle.
    assign w_bound = (!r_in_pkt && !w_beat) || (w_beat && mon_tlast);

    // Words 0..5 of each rule block are real; 6 and 7 are holes.
    assign w_slot  = (wr_addr[2:0] <= 3'd5);
    assign w_idx   = wr_addr[3] ? ({1'b0, wr_addr[2:0]} + 4'd6)
                                : {1'b0, wr_addr[2:0]};
    assign w_wr_ok = wr_en && w_slot && (r_state == S_IDLE);

    assign w_do_commit = (r_state == S_WAIT) && w_bound;
    assign w_do_abort  = (r_state == S_WAIT) && !w_bound && (r_tmo == TMAX);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_wr_err <= 1'b0;
            r_in_pkt <= 1'b0;
            r_tmo    <= '0;
            for (int i = 0; i < 12; i++) begin
                r_sh[i]  <= '0;
                r_act[i] <= '0;
            end
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_wr_err <= wr_en && (r_state != S_IDLE);

            if (w_beat) begin
                r_in_pkt <= !mon_tlast;
            end

            if (w_wr_ok) begin
                r_sh[w_idx] <= wr_data;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (commit_req) begin
                        r_state <= S_WAIT;
                        r_busy  <= 1'b1;
                        r_tmo   <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_do_commit) begin
                        for (int i = 0; i < 12; i++) begin
                            r_act[i] <= r_sh[i];
                        end
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_do_abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign pause_req   = r_busy;
    assign commit_done = r_done;
    assign commit_err  = r_err;
    assign wr_err      = r_wr_err;

    assign rule0_ipv4_addr = r_act[0];
    assign rule0_ipv6_addr = {r_act[4], r_act[3], r_act[2], r_act[1]};
    assign rule0_port      = r_act[5];
    assign rule1_ipv4_addr = r_act[6];
    assign rule1_ipv6_addr = {r_act[10], r_act[9], r_act[8], r_act[7]};
    assign rule1_port      = r_act[11];

`ifdef FILTER_COMMIT_STATS_EN
    logic [CNT_W-1:0] r_commit_cnt;
    logic [CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_commit_cnt <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            if (w_do_commit) begin
                r_commit_cnt <= r_commit_cnt + CNT_W'(1);
            end
            if (w_do_abort) begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end
        end
    end

    assign commit_count  = r_commit_cnt;
    assign timeout_count = r_tmo_cnt;
`else
    assign commit_count  = '0;
    assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_filter_rule_commit_ctrl.sv
// Testbench for filter_rule_commit_ctrl: table-driven shadow writes and
// commits with a scoreboard of expected rule sets, plus boundary sequences.
module tb_filter_rule_commit_ctrl;

    localparam int TMO   = 16;
    localparam int CNT_W = 16;
`ifdef FILTER_COMMIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [383:0] words_t;

    typedef struct {
        logic   err;
        words_t w;
    } sb_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        bit          commit;
        logic [31:0] exp_r0_ipv4;
        logic [31:0] exp_r1_port;
    } vec_t;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             wr_en = 1'b0;
    logic [3:0]       wr_addr = '0;
    logic [31:0]      wr_data = '0;
    logic             commit_req = 1'b0;
    logic             mon_tvalid = 1'b0;
    logic             mon_tready = 1'b0;
    logic             mon_tlast = 1'b0;
    logic             busy;
    logic             commit_done;
    logic             commit_err;
    logic             wr_err;
    logic             pause_req;
    logic [31:0]      rule0_ipv4_addr;
    logic [127:0]     rule0_ipv6_addr;
    logic [31:0]      rule0_port;
    logic [31:0]      rule1_ipv4_addr;
    logic [127:0]     rule1_ipv6_addr;
    logic [31:0]      rule1_port;
    logic [CNT_W-1:0] commit_count;
    logic [CNT_W-1:0] timeout_count;

    filter_rule_commit_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .commit_req(commit_req),
        .mon_tvalid(mon_tvalid),
        .mon_tready(mon_tready),
        .mon_tlast(mon_tlast),
        .busy(busy),
        .commit_done(commit_done),
        .commit_err(commit_err),
        .wr_err(wr_err),
        .pause_req(pause_req),
        .rule0_ipv4_addr(rule0_ipv4_addr),
        .rule0_ipv6_addr(rule0_ipv6_addr),
        .rule0_port(rule0_port),
        .rule1_ipv4_addr(rule1_ipv4_addr),
        .rule1_ipv6_addr(rule1_ipv6_addr),
        .rule1_port(rule1_port),
        .commit_count(commit_count),
        .timeout_count(timeout_count)
    );

    always #5 aclk = ~aclk;

    int     checks = 0;
    int     failures = 0;
    int     n_ok = 0;
    int     n_err = 0;
    int     lat;
    bit     got_done;
    bit     got_err;
    words_t sh = '0;
    words_t act = '0;
    sb_t    sb[$];
    vec_t   tbl[7];

    function automatic words_t dut_words();
        return {rule1_port, rule1_ipv6_addr, rule1_ipv4_addr,
                rule0_port, rule0_ipv6_addr, rule0_ipv4_addr};
    endfunction

    task automatic chk(input string name, input words_t a, input words_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, a, e);
        end
    endtask

    task automatic model_wr(input logic [3:0] a, input logic [31:0] d);
        int idx;
        idx = (a[3] ? 6 : 0) + int'(a[2:0]);
        if (a[2:0] <= 3'd5) sh[idx*32 +: 32] = d;
    endtask

    task automatic drive_wr(input logic [3:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic push_commit();
        sb_t e;
        e.err = 1'b0;
        e.w   = sh;
        sb.push_back(e);
    endtask

    task automatic push_abort();
        sb_t e;
        e.err = 1'b1;
        e.w   = act;
        sb.push_back(e);
    endtask

    task automatic step();
        sb_t e;
        @(posedge aclk);
        #1;
        got_done = commit_done;
        got_err  = commit_err;
        if (commit_done || commit_err) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=done%0b/err%0b required=none",
                         commit_done, commit_err);
            end else begin
                e = sb.pop_front();
                chk("sb_kind", words_t'({commit_done, commit_err}),
                    e.err ? words_t'(2'b01) : words_t'(2'b10));
                chk("sb_rules", dut_words(), e.w);
                if (e.err) n_err++;
                else begin
                    n_ok++;
                    act = e.w;
                end
            end
        end
    endtask

    task automatic wait_pulse(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(got_done || got_err) && n < max);
        if (!(got_done || got_err)) begin
            checks++;
            failures++;
            $display("FAIL wait_pulse actual=no_pulse required=pulse_within_%0d", max);
        end
    endtask

    initial begin
        tbl[0] = '{4'h1, 32'h20010DB8, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{4'h4, 32'hFFFF0000, 1'b0, 32'h0, 32'h0};
        tbl[2] = '{4'h6, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0};
        tbl[3] = '{4'hD, 32'h00001F90, 1'b1, 32'hC0A80001, 32'h00001F90};
        tbl[4] = '{4'h8, 32'h0A000001, 1'b0, 32'h0, 32'h0};
        tbl[5] = '{4'hF, 32'h12345678, 1'b0, 32'h0, 32'h0};
        tbl[6] = '{4'h0, 32'h01020304, 1'b1, 32'h01020304, 32'h00001F90};

        // reset state
        #1;
        chk("rst_busy", words_t'(busy), '0);
        chk("rst_pause", words_t'(pause_req), '0);
        chk("rst_rules", dut_words(), '0);
        chk("rst_pulses", words_t'({commit_done, commit_err, wr_err}), '0);
        chk("rst_counts", words_t'({commit_count, timeout_count}), '0);
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // idle commit with latency
        drive_wr(4'h0, 32'hC0A80001); model_wr(4'h0, 32'hC0A80001);
        step();
        drive_wr(4'h5, 32'h00000050); model_wr(4'h5, 32'h00000050);
        step();
        wr_en = 1'b0;
        commit_req = 1'b1;
        push_commit();
        step();
        commit_req = 1'b0;
        chk("idle_k1_busy", words_t'({busy, pause_req}), words_t'(2'b11));
        chk("idle_k1_done", words_t'(commit_done), '0);
        chk("idle_k1_old", words_t'(rule0_ipv4_addr), '0);
        step();
        chk("idle_k2_done", words_t'(got_done), words_t'(1'b1));
        chk("idle_k2_ipv4", words_t'(rule0_ipv4_addr), words_t'(32'hC0A80001));
        chk("idle_k2_port", words_t'(rule0_port), words_t'(32'h50));
        chk("idle_k2_busy", words_t'(busy), '0);
        chk("idle_cnt", words_t'(commit_count), STATS ? words_t'(1) : '0);
        step();
        chk("idle_done_1cyc", words_t'(commit_done), '0);

        // table of writes / commits
        for (int i = 0; i < 7; i++) begin
            drive_wr(tbl[i].addr, tbl[i].data);
            model_wr(tbl[i].addr, tbl[i].data);
            commit_req = tbl[i].commit;
            if (tbl[i].commit) push_commit();
            step();
            wr_en = 1'b0;
            commit_req = 1'b0;
            if (tbl[i].commit) begin
                wait_pulse(8, lat);
                chk("tbl_lat", words_t'(lat), words_t'(1));
                chk("tbl_r0_ipv4", words_t'(rule0_ipv4_addr),
                    words_t'(tbl[i].exp_r0_ipv4));
                chk("tbl_r1_port", words_t'(rule1_port),
                    words_t'(tbl[i].exp_r1_port));
            end
        end
        chk("tbl_r1_ipv4", words_t'(rule1_ipv4_addr), words_t'(32'h0A000001));
        chk("tbl_r0_ipv6", words_t'(rule0_ipv6_addr),
            words_t'(128'hFFFF0000_00000000_00000000_20010DB8));

        // mid-packet commit, busy write, commit_req while busy
        mon_tready = 1'b1;
        mon_tvalid = 1'b1;
        step();
        mon_tvalid = 1'b0;
        drive_wr(4'h9, 32'hAAAA5555); model_wr(4'h9, 32'hAAAA5555);
        commit_req = 1'b1;
        push_commit();
        step();
        drive_wr(4'h8, 32'hDEAD0001);
        step();
        wr_en = 1'b0;
        commit_req = 1'b0;
        chk("bw_wr_err", words_t'(wr_err), words_t'(1'b1));
        chk("mid_no_done", words_t'(commit_done), '0);
        mon_tvalid = 1'b1;
        step();
        chk("bw_wr_err_1cyc", words_t'(wr_err), '0);
        mon_tready = 1'b0;
        step();
        mon_tready = 1'b1;
        step();
        chk("mid_busy", words_t'(busy), words_t'(1'b1));
        chk("mid_old_ipv6", words_t'(rule1_ipv6_addr), '0);
        mon_tlast = 1'b1;
        step();
        mon_tvalid = 1'b0;
        mon_tlast = 1'b0;
        chk("mid_done", words_t'(got_done), words_t'(1'b1));
        chk("mid_ipv6", words_t'(rule1_ipv6_addr), words_t'(32'hAAAA5555));
        chk("bw_kept", words_t'(rule1_ipv4_addr), words_t'(32'h0A000001));

        // timeout with line stalled mid-packet
        mon_tvalid = 1'b1;
        step();
        mon_tvalid = 1'b0;
        drive_wr(4'h5, 32'h00001234); model_wr(4'h5, 32'h00001234);
        commit_req = 1'b1;
        push_abort();
        step();
        wr_en = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            commit_req = (i == 5);
            step();
            lat = i;
            if (got_err || got_done) break;
        end
        commit_req = 1'b0;
        chk("tmo_latency", words_t'(lat), words_t'(TMO));
        chk("tmo_err", words_t'(got_err), words_t'(1'b1));
        chk("tmo_port_kept", words_t'(rule0_port), words_t'(32'h50));
        chk("tmo_cnt", words_t'(timeout_count), STATS ? words_t'(1) : '0);
        chk("ok_cnt", words_t'(commit_count), STATS ? words_t'(n_ok) : '0);
        step();
        chk("tmo_err_1cyc", words_t'(commit_err), '0);
        mon_tvalid = 1'b1;
        mon_tlast = 1'b1;
        step();
        mon_tvalid = 1'b0;
        mon_tlast = 1'b0;
        commit_req = 1'b1;
        push_commit();
        step();
        commit_req = 1'b0;
        wait_pulse(8, lat);
        chk("tmo_retained", words_t'(rule0_port), words_t'(32'h1234));

        // async reset mid-WAIT
        mon_tvalid = 1'b1;
        step();
        mon_tvalid = 1'b0;
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        step();
        chk("rw_busy_pre", words_t'(busy), words_t'(1'b1));
        #2;
        aresetn = 1'b0;
        #1;
        chk("rw_busy", words_t'(busy), '0);
        chk("rw_rules", dut_words(), '0);
        chk("rw_counts", words_t'({commit_count, timeout_count}), '0);
        chk("rw_pulses", words_t'({commit_done, commit_err}), '0);
        sh = '0;
        act = '0;
        n_ok = 0;
        n_err = 0;
        repeat (2) begin
            step();
            chk("rw_no_pulse", words_t'({got_done, got_err}), '0);
        end
        aresetn = 1'b1;
        drive_wr(4'h0, 32'h00000055); model_wr(4'h0, 32'h00000055);
        commit_req = 1'b1;
        push_commit();
        step();
        wr_en = 1'b0;
        commit_req = 1'b0;
        wait_pulse(4, lat);
        chk("rw_after_ipv4", words_t'(rule0_ipv4_addr), words_t'(32'h55));
        chk("rw_after_cnt", words_t'(commit_count), STATS ? words_t'(1) : '0);

        chk("sb_empty", words_t'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_rule_commit_ctrl.md
Name: filter_rule_commit_ctrl

Overview:
- Configuration controller for the two-rule RX filter pipeline.
- Software writes rule values into shadow registers, then requests a commit.
- The controller copies shadow to active rule outputs only at an AXIS packet boundary, so no packet is ever filtered against a half-updated rule set.
- Sits between the register file and the filter pipeline's rule inputs; taps the pipeline's ingress AXIS handshake.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles in WAIT_BOUNDARY before abort; legal range 2..65535.
CNT_W, 16, width of optional commit/timeout counters.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
wr_en  in  1  shadow write strobe
wr_addr  in  4  shadow word address (map below)
wr_data  in  32  shadow write data
commit_req  in  1  single-cycle commit request
mon_tvalid  in  1  ingress s_axis_tvalid tap
mon_tready  in  1  ingress s_axis_tready tap
mon_tlast  in  1  ingress s_axis_tlast tap
busy  out  1  commit pending (state != IDLE)
commit_done  out  1  one-cycle pulse: active rules updated
commit_err  out  1  one-cycle pulse: commit aborted on timeout
wr_err  out  1  one-cycle pulse: write dropped while busy
pause_req  out  1  asks upstream to hold off the next packet start; asserted in WAIT_BOUNDARY
rule0_ipv4_addr  out  32  active rule 0 IPv4
rule0_ipv6_addr  out  128  active rule 0 IPv6
rule0_port  out  32  active rule 0 port
rule1_ipv4_addr  out  32  active rule 1 IPv4
rule1_ipv6_addr  out  128  active rule 1 IPv6
rule1_port  out  32  active rule 1 port
commit_count  out  CNT_W  successful commits (optional feature)
timeout_count  out  CNT_W  aborted commits (optional feature)

Behaviour:
- Reset: all shadow and active registers 0; state IDLE; in_pkt 0; all outputs 0.
- Shadow address map (unlisted addresses ignored, no error):
  - 0x0: r0 ipv4.
  - 0x1–0x4: r0 ipv6 bits [31:0], [63:32], [95:64], [127:96].
  - 0x5: r0 port.
  - 0x8–0xD: same layout for rule 1.
- Packet tracking, beat = mon_tvalid & mon_tready:
  - in_pkt sets on a beat with !mon_tlast.
  - in_pkt clears on a beat with mon_tlast.
  - A single-beat packet leaves in_pkt at 0.
- Boundary condition, evaluated in WAIT_BOUNDARY:
  - (in_pkt==0 and no beat this cycle), or
  - (beat with mon_tlast this cycle).
- States:
  - IDLE: on commit_req, go to WAIT_BOUNDARY and clear the timeout counter. A wr_en in the same cycle is written first and is included in the commit.
  - WAIT_BOUNDARY, boundary met: at the clock edge, copy all shadow words to active, pulse commit_done, go to IDLE.
  - WAIT_BOUNDARY, otherwise: increment the timeout counter. When it reaches TIMEOUT_CYCLES-1 without a boundary: pulse commit_err, go to IDLE, leave active unchanged, keep shadow.
- Latency: commit_req in cycle k with the line idle gives busy=1 and pause_req=1 in cycle k+1, then new active values and commit_done=1 in cycle k+2.
- Writes while busy: dropped, shadow unchanged, wr_err pulses in the next cycle.
- commit_req while busy: ignored; no error, no effect on the timer.
- Active outputs change only on a commit edge and are glitch-free registered outputs.
- Async reset mid-WAIT: immediate return to reset values; no done or err pulse.
- Timeout counter width: clog2(TIMEOUT_CYCLES) bits. It saturates and never wraps before the abort.

Optional Feature:
- Macro FILTER_COMMIT_STATS_EN.
- Defined:
  - commit_count increments on each commit_done.
  - timeout_count increments on each commit_err.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: both ports tied to 0 and no counter flops are built.

Test Plan:
- Idle commit: write 0x0=0xC0A80001 and 0x5=0x50, commit_req at cycle k, no traffic → rule0_ipv4_addr=0xC0A80001 and rule0_port=0x50 at k+2; commit_done=1 for exactly one cycle; commit_count=1.
- Mid-packet commit: 4-beat packet with beat 1 accepted, then commit_req → active unchanged until the tlast beat is accepted; active update and commit_done on that edge.
- Timeout: TIMEOUT_CYCLES=16, packet stalls mid-packet (mon_tvalid=0) → commit_err pulses 16 cycles after entering WAIT; active unchanged; timeout_count=1; later idle commit applies the retained shadow.
- Busy write: commit pending, wr_en 0x8=0x0A000001 → wr_err=1 for one cycle; after commit, rule1_ipv4_addr keeps its previous shadow value.
- Same-cycle write+commit: wr_en 0xD=0x1F90 with commit_req, idle line → rule1_port=0x1F90 at k+2.
- Reset mid-WAIT: aresetn low while busy → busy=0, all rule outputs 0 and counters 0 immediately; no commit_done or commit_err pulse.
